// File: rtl/axi_burst_rd_responder_if.sv
// Read-burst channel (ar/r) plus the single-beat sram-like memory port of the burst responder.
interface axi_burst_rd_responder_if;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;

    modport slave (
        input  araddr, arlen, arsize, arvalid, rready, mem_rdata, mem_addr_ok, mem_data_ok,
        output arready, rdata, rlast, rvalid, mem_req, mem_wr, mem_size, mem_addr
    );

    modport master (
        output araddr, arlen, arsize, arvalid, rready, mem_rdata, mem_addr_ok, mem_data_ok,
        input  arready, rdata, rlast, rvalid, mem_req, mem_wr, mem_size, mem_addr
    );
endinterface

// File: rtl/axi_burst_rd_responder.sv
// Splits one read burst into single-beat memory reads and returns the beats in order
// through a small FIFO that absorbs rready backpressure.
module axi_burst_rd_responder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_burst_rd_responder_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]                  state;
    logic [31:0]                 cur_addr;
    logic [3:0]                  len;
    logic [1:0]                  size;
    logic [4:0]                  issued;
    logic [3:0]                  returned;
    logic                        outstanding;
    logic [FIFO_DEPTH-1:0][31:0] fifo;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [CW-1:0]               count;

    logic arready;
    logic ar_fire;
    logic mem_req;
    logic issue;
    logic push;
    logic pop;
    logic rvalid;
    logic rlast;
    logic fifo_full;

    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign arready   = (state == IDLE) & ~rst;
    assign ar_fire   = bus.arvalid & arready;

    // Issue needs a free slot, so the single outstanding read can never overflow the FIFO.
    assign mem_req = (state == BUSY) & ~rst & ~outstanding & (issued <= {1'b0, len}) & ~fifo_full;
    assign issue   = mem_req & bus.mem_addr_ok;
    assign push    = outstanding & bus.mem_data_ok;

    assign rvalid = (count != '0) & ~rst;
    assign rlast  = rvalid & (returned == len);
    assign pop    = rvalid & bus.rready;

    assign bus.arready  = arready;
    assign bus.mem_req  = mem_req;
    assign bus.mem_wr   = 1'b0;
    assign bus.mem_size = size;
    assign bus.mem_addr = cur_addr;
    assign bus.rvalid   = rvalid;
    assign bus.rlast    = rlast;
    assign bus.rdata    = rvalid ? fifo[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_addr    <= '0;
            len         <= '0;
            size        <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= 1'b0;
        end else if (ar_fire) begin
            state       <= BUSY;
            cur_addr    <= bus.araddr;
            len         <= bus.arlen;
            size        <= (bus.arsize > 3'd2) ? 2'd2 : bus.arsize[1:0];
            issued      <= '0;
            returned    <= '0;
            outstanding <= 1'b0;
        end else if (state == BUSY) begin
            if (issue) begin
                cur_addr    <= cur_addr + (32'd1 << size);
                issued      <= issued + 5'd1;
                outstanding <= 1'b1;
            end else if (push) begin
                outstanding <= 1'b0;
            end
            if (pop) begin
                returned <= returned + 4'd1;
                if (rlast)
                    state <= IDLE;
            end
        end
    end

    // Pointers and count carry the reset; stale storage is never visible once count is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= bus.mem_rdata;
    end
endmodule
